// File: rtl/pipe_pkg.sv
// Shared pipeline-latch definitions: occupancy state encoding and helpers.
// The encoding is chosen so that the state value equals the number of held words.
package pipe_pkg;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  // Occupancy is the state value itself, given the encoding above.
  function automatic logic [1:0] occ_of(input logic [1:0] st);
    return st;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MaxCnt = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MaxCnt)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Pipeline latch with optional 2-entry skid buffer, flush and a saturating stall counter.
// SKID_EN=1 registers up_ready_o; SKID_EN=0 is a plain stall latch with combinational ready.
module pipe_skid_latch #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import pipe_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q;
  logic              up_fire, dn_fire;

  assign up_fire = up_valid_i & up_ready_o;
  assign dn_fire = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (kill_i) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (up_fire) begin
            state_d = StOne;
            main_d  = up_data_i;
          end
        end
        StOne: begin
          if (up_fire && dn_fire) begin
            main_d = up_data_i;
          end else if (dn_fire) begin
            state_d = StEmpty;
          end else if (up_fire && SKID_EN) begin
            state_d = StTwo;
            skid_d  = up_data_i;
          end
        end
        StTwo: begin
          if (dn_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Ready for next cycle is decided from next state, keeping dn_ready_i off the path.
      up_ready_q <= (state_d != StTwo);
    end
  end

  assign up_ready_o  = SKID_EN ? up_ready_q : (dn_ready_i | (state_q == StEmpty));
  assign dn_valid_o  = (state_q != StEmpty);
  assign dn_data_o   = main_q;
  assign occupancy_o = occ_of(state_q);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(dn_valid_o & ~dn_ready_i & ~kill_i),
    .cnt_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed bench: skid-mode DUT with a data scoreboard, plus plain-mode and 3-bit-counter DUTs.
module tb_pipe_skid_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Skid mode, default widths
  logic        kill, up_valid, up_ready, dn_valid, dn_ready;
  logic [31:0] up_data, dn_data;
  logic [1:0]  occ;
  logic [15:0] stall;

  // Plain mode
  logic        p_kill, p_up_valid, p_up_ready, p_dn_valid, p_dn_ready;
  logic [7:0]  p_up_data, p_dn_data;
  logic [1:0]  p_occ;
  logic [15:0] p_stall;

  // Skid mode, 3-bit stall counter
  logic        s_kill, s_up_valid, s_up_ready, s_dn_valid, s_dn_ready;
  logic [7:0]  s_up_data, s_dn_data;
  logic [1:0]  s_occ;
  logic [2:0]  s_stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  pipe_skid_latch #(.DATA_W(32), .SKID_EN(1'b1), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .up_valid_i(up_valid), .up_ready_o(up_ready),
    .up_data_i(up_data), .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data),
    .occupancy_o(occ), .stall_cnt_o(stall)
  );

  pipe_skid_latch #(.DATA_W(8), .SKID_EN(1'b0), .CNT_W(16)) u_plain (
    .clk_i(clk), .rst_i(rst), .kill_i(p_kill), .up_valid_i(p_up_valid),
    .up_ready_o(p_up_ready), .up_data_i(p_up_data), .dn_valid_o(p_dn_valid),
    .dn_ready_i(p_dn_ready), .dn_data_o(p_dn_data), .occupancy_o(p_occ),
    .stall_cnt_o(p_stall)
  );

  pipe_skid_latch #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .kill_i(s_kill), .up_valid_i(s_up_valid),
    .up_ready_o(s_up_ready), .up_data_i(s_up_data), .dn_valid_o(s_dn_valid),
    .dn_ready_i(s_dn_ready), .dn_data_o(s_dn_data), .occupancy_o(s_occ),
    .stall_cnt_o(s_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the skid DUT: drive, sample at negedge, update scoreboard, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic k,
                      input logic exp_rdy);
    up_valid = v;
    up_data  = d;
    dn_ready = r;
    kill     = k;
    @(negedge clk);
    chk("up_ready", up_ready, exp_rdy);
    if (dn_valid && r) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("dn_data_order", dn_data, sb.pop_front());
    end
    if (k) sb.delete();
    else if (v && exp_rdy) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    kill = 0; up_valid = 0; up_data = '0; dn_ready = 0;
    p_kill = 0; p_up_valid = 0; p_up_data = '0; p_dn_ready = 0;
    s_kill = 0; s_up_valid = 0; s_up_data = '0; s_dn_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset values
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_dn_data", dn_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_stall", stall, 0);
    chk("rst_up_ready", up_ready, 1);

    // Streaming
    step(1, 32'h11, 1, 0, 1);
    step(1, 32'h22, 1, 0, 1);
    step(1, 32'h33, 1, 0, 1);
    step(0, 32'h0, 1, 0, 1);
    chk("stream_drained", sb.size(), 0);
    chk("stream_stall", stall, 0);
    chk("stream_occ", occ, 0);

    // Backpressure into the skid slot
    step(1, 32'h11, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);
    step(1, 32'h22, 0, 0, 1);
    chk("bp_occ", occ, 2);
    chk("bp_ready_low", up_ready, 0);
    chk("bp_hold_data", dn_data, 32'h11);
    chk("bp_stall", stall, 2);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 1);
    chk("bp_drained", sb.size(), 0);
    chk("bp_stall_final", stall, 2);

    // Kill from TWO
    step(1, 32'hA1, 0, 0, 1);
    step(1, 32'hA2, 0, 0, 1);
    chk("kill_pre_occ", occ, 2);
    step(0, 32'h0, 0, 1, 0);
    chk("kill_dn_valid", dn_valid, 0);
    chk("kill_dn_data", dn_data, 0);
    chk("kill_occ", occ, 0);
    chk("kill_up_ready", up_ready, 1);
    chk("kill_stall_kept", stall, 3);

    // Kill with simultaneous dn-fire (delivered) and up-fire (discarded)
    step(1, 32'hB1, 1, 0, 1);
    step(1, 32'hB2, 1, 1, 1);
    chk("kill2_occ", occ, 0);
    chk("kill2_dn_data", dn_data, 0);

    // Reset together with kill while in TWO
    step(1, 32'hC1, 0, 0, 1);
    step(1, 32'hC2, 0, 0, 1);
    chk("mid_pre_stall", stall, 4);
    up_valid = 0; rst = 1; kill = 1;
    @(posedge clk);
    #1;
    rst = 0; kill = 0;
    sb.delete();
    chk("mid_rst_dn_valid", dn_valid, 0);
    chk("mid_rst_dn_data", dn_data, 0);
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_up_ready", up_ready, 1);

    // Plain mode: ready follows dn_ready while a word is held
    p_up_valid = 1; p_up_data = 8'h44; p_dn_ready = 0;
    @(posedge clk); #1;
    chk("plain_ready_low", p_up_ready, 0);
    chk("plain_occ1", p_occ, 1);
    p_up_data = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("plain_occ_max", p_occ, 1);
    chk("plain_hold", p_dn_data, 8'h44);
    p_dn_ready = 1;
    #1;
    chk("plain_ready_comb", p_up_ready, 1);
    @(posedge clk); #1;
    chk("plain_pass_data", p_dn_data, 8'h55);
    chk("plain_pass_occ", p_occ, 1);
    p_up_valid = 0;
    @(posedge clk); #1;
    chk("plain_empty", p_occ, 0);
    p_up_valid = 1; p_up_data = 8'h66; p_dn_ready = 0;
    @(posedge clk); #1;
    p_up_valid = 0; p_kill = 1;
    @(posedge clk); #1;
    p_kill = 0;
    chk("plain_kill_ready", p_up_ready, 1);
    chk("plain_kill_occ", p_occ, 0);
    chk("plain_kill_data", p_dn_data, 0);

    // Counter saturation with CNT_W=3
    s_up_valid = 1; s_up_data = 8'h5A; s_dn_ready = 0;
    @(posedge clk); #1;
    s_up_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_mid", s_stall, 3);
    repeat (7) @(posedge clk);
    #1;
    chk("sat_max", s_stall, 7);
    chk("sat_hold_data", s_dn_data, 8'h5A);
    s_dn_ready = 1;
    @(posedge clk); #1;
    chk("sat_stays", s_stall, 7);
    chk("sat_drained", s_occ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
